// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: request synchroniser, masked pending latch and highest-index presenter.
// Build option IRQ_EDGE_DETECT_EN: pend on rising edge of the synchronised level.
module irq_pending_ctrl #(
    parameter int N           = 8,
    parameter int IDW         = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    output logic [N-1:0]   pend_o,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    input  logic           irq_ack,
    output logic [N-1:0]   ovf,
    input  logic           ovf_clr
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        SETTLE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   sync_q [SYNC_STAGES];
    logic [N-1:0]   lvl;
    logic [N-1:0]   detect;
    logic [N-1:0]   clr;
    logic [N-1:0]   pending;
    logic [N-1:0]   pend_nx;
    logic [N-1:0]   ovf_nx;
    logic [IDW-1:0] top_id;
    logic           ack_fire;
    logic           load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= req;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign lvl = sync_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= '0;
        else        lvl_q <= lvl;
    end

    assign detect = lvl & ~lvl_q;
`else
    assign detect = lvl;
`endif

    always_comb begin
        clr = '0;
        if (ack_fire) clr[irq_id] = 1'b1;
    end

    // Set beats the ack-clear, so a coincident request re-pends.
    assign pend_nx = detect | (pending & ~clr);
    assign ovf_nx  = (detect & pending & ~clr) | (ovf_clr ? '0 : ovf);

    always_comb begin
        top_id = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_o[i]) top_id = IDW'(i);
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        ack_fire = 1'b0;
        case (state)
            IDLE: begin
                if (|pend_o) begin
                    load     = 1'b1;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    ack_fire = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            pend_o    <= '0;
            ovf       <= '0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            state   <= state_nx;
            pending <= pend_nx;
            pend_o  <= pending & mask;
            ovf     <= ovf_nx;
            if (load) begin
                irq_valid <= 1'b1;
                irq_id    <= top_id;
            end else if (ack_fire) begin
                irq_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: cycle model compared every cycle plus directed
// literal expectations for reset, priority, masking, overflow and re-pend cases.
module tb_irq_pending_ctrl;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic [N-1:0] pend_o;
    logic         irq_valid;
    logic [W-1:0] irq_id;
    logic         irq_ack;
    logic [N-1:0] ovf;
    logic         ovf_clr;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    irq_pending_ctrl #(.N(N), .IDW(W), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .mask     (mask),
        .pend_o   (pend_o),
        .irq_valid(irq_valid),
        .irq_id   (irq_id),
        .irq_ack  (irq_ack),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Model: m_hist[j] holds req as sampled j+1 edges ago.
    logic [N-1:0] m_hist [0:SS];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_pend_o;
    logic [N-1:0] m_ovf;
    logic [N-1:0] m_det;
    logic [N-1:0] m_np;
    bit           m_valid;
    int           m_id;
    int           m_cool;
    int           m_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= SS; j++) m_hist[j] = '0;
            m_pend   = '0;
            m_pend_o = '0;
            m_ovf    = '0;
            m_valid  = 1'b0;
            m_id     = 0;
            m_cool   = 0;
        end else begin
            m_clr = -1;
            if (m_valid && irq_ack) m_clr = m_id;
            for (int i = 0; i < N; i++) begin
`ifdef IRQ_EDGE_DETECT_EN
                m_det[i] = m_hist[SS-1][i] && !m_hist[SS][i];
`else
                m_det[i] = m_hist[SS-1][i];
`endif
                if (m_det[i]) m_np[i] = 1'b1;
                else if (i == m_clr) m_np[i] = 1'b0;
                else m_np[i] = m_pend[i];
                if (m_det[i] && m_pend[i] && i != m_clr) m_ovf[i] = 1'b1;
                else if (ovf_clr) m_ovf[i] = 1'b0;
            end
            if (m_valid) begin
                if (irq_ack) begin
                    m_valid = 1'b0;
                    m_cool  = 1;
                end
            end else if (m_cool > 0) begin
                m_cool = m_cool - 1;
            end else if (m_pend_o != 0) begin
                for (int i = 0; i < N; i++) if (m_pend_o[i]) m_id = i;
                m_valid = 1'b1;
            end
            m_pend_o = m_pend & mask;
            m_pend   = m_np;
            for (int j = SS; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = req;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("model_pend_o", 32'(pend_o), 32'(m_pend_o));
            chk("model_valid", 32'(irq_valid), 32'(m_valid));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
            if (m_valid) chk("model_id", 32'(irq_id), 32'(m_id));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] v, input int n);
        req = v;
        repeat (n) step();
        req = '0;
    endtask

    task automatic drain();
        req = '0;
        repeat (16) begin
            step();
            if (irq_valid) begin
                irq_ack = 1'b1;
                step();
                irq_ack = 1'b0;
            end
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step();
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        mask    = 8'hFF;
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
        #12;
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_pend_o", 32'(pend_o), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        step();
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        step();

        // single request on channel 2
        req = 8'h04;
        step(); step(); step();
        req = '0;
        step();
        chk("single_pend_o", 32'(pend_o), 32'h04);
        chk("single_early", 32'(irq_valid), 32'd0);
        step();
        chk("single_valid", 32'(irq_valid), 32'd1);
        chk("single_id", 32'(irq_id), 32'd2);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("single_drop", 32'(irq_valid), 32'd0);
        step();
        chk("single_clr", 32'(pend_o), 32'h00);
        drain();

        // priority: 5 before 0
        req = 8'h21;
        step(); step(); step();
        req = '0;
        step(); step();
        chk("prio_id5", 32'(irq_id), 32'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        chk("prio_settle", 32'(irq_valid), 32'd0);
        step();
        chk("prio_valid0", 32'(irq_valid), 32'd1);
        chk("prio_id0", 32'(irq_id), 32'd0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        chk("prio_empty", 32'(pend_o), 32'h00);
        chk("prio_idle", 32'(irq_valid), 32'd0);
        drain();

        // masking of channel 7
        mask = 8'h7F;
        req  = 8'h88;
        step(); step(); step();
        req = '0;
        step();
        chk("mask_pend_o", 32'(pend_o), 32'h08);
        step();
        chk("mask_id3", 32'(irq_id), 32'd3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        mask    = 8'hFF;
        step(); step();
        chk("mask_valid7", 32'(irq_valid), 32'd1);
        chk("mask_id7", 32'(irq_id), 32'd7);
        drain();

        // overflow on channel 1, held pending by mask
        mask = 8'hFD;
        pulse(8'h02, 1);
        repeat (4) step();
        chk("ovf_none", 32'(ovf), 32'h00);
        pulse(8'h02, 1);
        step(); step();
        chk("ovf_set", 32'(ovf), 32'h02);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'h00);
        mask = 8'hFF;
        drain();

`ifdef IRQ_EDGE_DETECT_EN
        // second edge on ch4 lands on the ack edge
        req = 8'h10;
        step();
        req = '0;
        step(); step();
        req = 8'h10;
        step();
        req = '0;
        step();
        chk("coin_valid", 32'(irq_valid), 32'd1);
        chk("coin_id", 32'(irq_id), 32'd4);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        chk("coin_pend_o", 32'(pend_o), 32'h10);
        chk("coin_ovf", 32'(ovf), 32'h00);
        step();
        chk("coin_repres", 32'(irq_valid), 32'd1);
        chk("coin_id2", 32'(irq_id), 32'd4);
        drain();
`else
        // held level on ch6 re-presents every 3 cycles
        req = 8'h40;
        repeat (5) step();
        chk("lvl_valid", 32'(irq_valid), 32'd1);
        chk("lvl_id", 32'(irq_id), 32'd6);
        repeat (2) begin
            irq_ack = 1'b1;
            step();
            irq_ack = 1'b0;
            chk("lvl_gap1", 32'(irq_valid), 32'd0);
            step();
            chk("lvl_gap2", 32'(irq_valid), 32'd0);
            step();
            chk("lvl_again", 32'(irq_valid), 32'd1);
            chk("lvl_id6", 32'(irq_id), 32'd6);
        end
        drain();
`endif

        // async reset in the middle of a presentation
        req = 8'hFF;
        repeat (5) step();
        chk("pre_rst_valid", 32'(irq_valid), 32'd1);
        chk("pre_rst_id", 32'(irq_id), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(irq_valid), 32'd0);
        chk("arst_pend_o", 32'(pend_o), 32'h00);
        chk("arst_ovf", 32'(ovf), 32'h00);
        req = '0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst", 32'(irq_valid), 32'd0);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
